// File: rtl/tt_um_pwm_multi.sv
// Multi-channel PWM with a shared period counter and double-buffered duty registers.
// Optional output inversion via ctrl[4] is compiled in when PWM_INVERT_EN is defined.
module tt_um_pwm_multi #(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [1:0]            strobe_sync_reg;
   logic                  strobe_prev_reg;
   logic [7:0]            ctrl_reg;
   logic [PRESCALE_W-1:0] presc_cnt_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  sync_reg;
   logic [CHANNELS-1:0]   pwm_reg;

   logic                  wr_fire;
   logic [2:0]            wr_addr;
   logic                  ctrl_wr;
   logic                  en;
   logic                  inv;
   logic                  tick;
   logic                  wrap;
   logic                  unused_ok;

   // Synchroniser runs even while ena=0 so a strobe already high at enable is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_sync_reg <= '0;
         strobe_prev_reg <= 1'b0;
      end else begin
         strobe_sync_reg <= {strobe_sync_reg[0], ui_in[7]};
         strobe_prev_reg <= strobe_sync_reg[1];
      end
   end

   assign wr_fire = ena & strobe_sync_reg[1] & ~strobe_prev_reg;
   assign wr_addr = ui_in[6:4];
   assign ctrl_wr = wr_fire & (wr_addr == 3'd7);
   assign en      = ctrl_reg[7];

`ifdef PWM_INVERT_EN
   assign inv = ctrl_reg[4];
`else
   assign inv = 1'b0;
`endif

   assign tick = en & (presc_cnt_reg == ctrl_reg[PRESCALE_W-1:0]);
   assign wrap = tick & (cnt_reg == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_reg      <= 8'h00;
         presc_cnt_reg <= '0;
         cnt_reg       <= '0;
         sync_reg      <= 1'b0;
      end else if (ena) begin
         if (ctrl_wr)
            ctrl_reg <= uio_in;
         if (ctrl_wr || !en || tick)
            presc_cnt_reg <= '0;
         else
            presc_cnt_reg <= presc_cnt_reg + 1'b1;
         if (!en)
            cnt_reg <= '0;
         else if (tick)
            cnt_reg <= cnt_reg + 1'b1;
         sync_reg <= wrap;
      end
   end

   // Per-channel shadow/active pair; a shadow write coinciding with a wrap lands after the copy.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [CNT_W-1:0] shadow_reg;
         logic [CNT_W-1:0] active_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_reg  <= '0;
               active_reg  <= '0;
               pwm_reg[gi] <= 1'b0;
            end else if (ena) begin
               if (wr_fire && (wr_addr == 3'(gi)))
                  shadow_reg <= uio_in[CNT_W-1:0];
               if (wrap)
                  active_reg <= shadow_reg;
               pwm_reg[gi] <= en & ((cnt_reg < active_reg) ^ inv);
            end
         end
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_out
         if (gi < CHANNELS) begin : g_pwm
            assign uo_out[gi] = pwm_reg[gi];
         end else begin : g_zero
            assign uo_out[gi] = 1'b0;
         end
      end
   endgenerate

   assign uo_out[7] = sync_reg;
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;

   assign unused_ok = ^{ui_in[3:0], uio_in, ctrl_reg};

endmodule

// File: tb/tb_tt_um_pwm_multi.sv
// Directed bench for tt_um_pwm_multi: duty, prescale, double-buffer timing, address decode, enables.
module tb_tt_um_pwm_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;
   int hi_cnt [4];

   tt_um_pwm_multi dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
      @(negedge clk);
      ui_in  = {1'b0, addr, 4'h0};
      uio_in = data;
      @(negedge clk);
      ui_in[7] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[7] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_sync();
      int found;
      found = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (uo_out[7]) begin
            found = 1;
            break;
         end
      end
      check("sync_seen", found, 1);
   endtask

   // Starts at the negedge of a sync cycle, ends at the negedge of the next one.
   // Sample k reflects the counter value of cycle k-1, so k=1..p covers one full period.
   task automatic run_period(input string tag, input int p, input int wr_k,
                             input logic [2:0] wr_addr, input logic [7:0] wr_data);
      int sync_mid;
      sync_mid = 0;
      for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
      for (int k = 1; k <= p; k++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) hi_cnt[c] += int'(uo_out[c]);
         if (k < p) sync_mid += int'(uo_out[7]);
         else check({tag, "_sync_end"}, int'(uo_out[7]), 1);
         if (wr_k > 0) begin
            if (k == wr_k - 2) begin
               ui_in  = {1'b0, wr_addr, 4'h0};
               uio_in = wr_data;
            end
            if (k == wr_k) ui_in[7] = 1'b1;
            if (k == wr_k + 3) ui_in[7] = 1'b0;
         end
      end
      check({tag, "_sync_mid"}, sync_mid, 0);
   endtask

   task automatic quiet(input string tag, input int n);
      int nz;
      nz = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (uo_out != 8'h00) nz++;
      end
      check(tag, nz, 0);
   endtask

   initial begin
      int exp_hi0;
      int exp_hi3;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_uo_out", int'(uo_out), 0);
      check("rst_uio_oe", int'(uio_oe), 0);
      check("rst_uio_out", int'(uio_out), 0);
      rst_n = 1'b1;
      quiet("idle_after_reset", 300);

      // ch0 64/256, ch1 duty 0
      write_reg(3'd0, 8'd64);
      write_reg(3'd7, 8'h80);
      wait_sync();
      run_period("p0", 256, 0, 3'd0, 8'h00);
      check("p0_ch0_high", hi_cnt[0], 64);
      check("p0_ch1_high", hi_cnt[1], 0);

      // prescale 3: period 1024 cycles, duty 255 low for one tick
      write_reg(3'd1, 8'd255);
      write_reg(3'd7, 8'h83);
      wait_sync();
      run_period("p1", 1024, 0, 3'd0, 8'h00);
      check("p1_ch0_high", hi_cnt[0], 256);
      check("p1_ch1_high", hi_cnt[1], 1020);

      // double buffering of duty2
      write_reg(3'd2, 8'd100);
      write_reg(3'd7, 8'h80);
      wait_sync();
      run_period("p2", 256, 0, 3'd0, 8'h00);
      check("p2_ch2_high", hi_cnt[2], 100);
      run_period("p3", 256, 50, 3'd2, 8'd200);
      check("p3_ch2_midwrite_old", hi_cnt[2], 100);
      run_period("p4", 256, 0, 3'd0, 8'h00);
      check("p4_ch2_new", hi_cnt[2], 200);
      run_period("p5", 256, 253, 3'd2, 8'd30);
      check("p5_ch2_before_wrapwrite", hi_cnt[2], 200);
      run_period("p6", 256, 0, 3'd0, 8'h00);
      check("p6_ch2_not_captured", hi_cnt[2], 200);
      run_period("p7", 256, 0, 3'd0, 8'h00);
      check("p7_ch2_applied", hi_cnt[2], 30);

      // unmapped address 5, then duty0=0
      write_reg(3'd5, 8'h11);
      write_reg(3'd0, 8'd0);
      wait_sync();
      run_period("p8", 256, 0, 3'd0, 8'h00);
      check("p8_ch0_zero", hi_cnt[0], 0);
      check("p8_ch1", hi_cnt[1], 255);
      check("p8_ch2", hi_cnt[2], 30);
      check("p8_ch3", hi_cnt[3], 0);

      // INV bit; outputs must be inverted only when the feature is compiled in
`ifdef PWM_INVERT_EN
      exp_hi0 = 192;
      exp_hi3 = 256;
`else
      exp_hi0 = 64;
      exp_hi3 = 0;
`endif
      write_reg(3'd0, 8'd64);
      write_reg(3'd7, 8'h90);
      wait_sync();
      run_period("p9", 256, 0, 3'd0, 8'h00);
      check("p9_ch0_inv", hi_cnt[0], exp_hi0);
      check("p9_ch3_inv", hi_cnt[3], exp_hi3);
      write_reg(3'd7, 8'h10);
      repeat (2) @(negedge clk);
      quiet("en0_with_inv_quiet", 300);

      // ena=0 ignores writes; strobe held high across ena rising must not fire
      @(negedge clk);
      ena    = 1'b0;
      ui_in  = {1'b0, 3'd7, 4'h0};
      uio_in = 8'h80;
      @(negedge clk);
      ui_in[7] = 1'b1;
      repeat (5) @(negedge clk);
      ena = 1'b1;
      repeat (5) @(negedge clk);
      ui_in[7] = 1'b0;
      quiet("ena_gated_write_quiet", 600);

      // asynchronous reset mid-run
      write_reg(3'd7, 8'h80);
      wait_sync();
      repeat (5) @(negedge clk);
      check("prerst_ch0_high", int'(uo_out[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_uo_out", int'(uo_out), 0);
      check("async_rst_uio_oe", int'(uio_oe), 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("after_midrun_reset_quiet", 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
